dds_phase_gen: RTL and testbench

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

---
 rtl/dds_pkg.sv | 23 ++
 rtl/dds_phase_gen_if.sv | 26 ++
 rtl/dds_quad_fold.sv | 68 ++++++
 rtl/dds_phase_gen.sv | 123 ++++++++++++
 tb/tb_dds_phase_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared defaults and quadrant encoding for the DDS phase generator.
// The helpers say which quadrants read the quarter-wave table backwards and which negate the sample.
package dds_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int ADDR_W_DEF  = 10;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } quad_e;

    function automatic logic quad_mirror(input quad_e q);
        return (q == Q1) || (q == Q3);
    endfunction

    function automatic logic quad_negate(input quad_e q);
        return (q == Q2) || (q == Q3);
    endfunction

endpackage

// File: rtl/dds_phase_gen_if.sv
// Configuration handshake and sample output bundle of the DDS phase generator.
interface dds_phase_gen_if
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] fw_in;
    logic [PHASE_W-1:0] pw_in;
    logic               out_valid;
    logic [ADDR_W-1:0]  rom_addr;
    logic               neg;
    logic               wrap;

    modport master (
        output cfg_valid, fw_in, pw_in,
        input  cfg_ready, out_valid, rom_addr, neg, wrap
    );

    modport slave (
        input  cfg_valid, fw_in, pw_in,
        output cfg_ready, out_valid, rom_addr, neg, wrap
    );
endinterface

// File: rtl/dds_quad_fold.sv
// Output stage: folds a full phase word onto a quarter-wave table address and a negate flag.
// Data outputs hold between valid pulses, and a clear kills the sample currently entering.
module dds_quad_fold
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               valid_i,
    input  logic [PHASE_W-1:0] ph_i,
    input  logic               wrap_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               neg_o,
    output logic               wrap_o
);
    quad_e             quad;
    logic              mirror;
    logic              neg_d;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] addr_d;
    logic              ph_unused;

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              neg_q;
    logic              wrap_q;

    assign quad   = quad_e'(ph_i[PHASE_W-1 -: 2]);
    assign idx    = ph_i[PHASE_W-3 -: ADDR_W];
    assign mirror = quad_mirror(quad);
    assign neg_d  = quad_negate(quad);

    // Phase bits below the table resolution are deliberately discarded.
    assign ph_unused = &{1'b0, ph_i};

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_fold
            assign addr_d[gi] = idx[gi] ^ mirror;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            neg_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            valid_q <= valid_i && !clr_i;
            if (valid_i && !clr_i) begin
                addr_q <= addr_d;
                neg_q  <= neg_d;
                wrap_q <= wrap_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign neg_o   = neg_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: ce-gated phase accumulator with double-buffered tuning/offset words,
// a phase-offset stage, and a quadrant fold stage driving a quarter-wave ROM address.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         sync_clr,
    dds_phase_gen_if.slave bus
);
    logic [PHASE_W-1:0] acc_q,    acc_d;
    logic [PHASE_W-1:0] fw_act_q, fw_act_d;
    logic [PHASE_W-1:0] pw_act_q, pw_act_d;
    logic [PHASE_W-1:0] fw_sh_q,  fw_sh_d;
    logic [PHASE_W-1:0] pw_sh_q,  pw_sh_d;
    logic               pending_q, pending_d;
    logic               v1_q,     v1_d;
    logic               wrap1_q,  wrap1_d;
    logic [PHASE_W-1:0] ph_q,     ph_d;
    logic               v2_q,     v2_d;
    logic               wrap2_q,  wrap2_d;

    logic               hs;
    logic [PHASE_W-1:0] fw_use;
    logic [PHASE_W:0]   sum;

    assign hs     = bus.cfg_valid && !pending_q;
    assign fw_use = pending_q ? fw_sh_q : fw_act_q;
    assign sum    = {1'b0, acc_q} + {1'b0, fw_use};

    always_comb begin
        acc_d     = acc_q;
        fw_act_d  = fw_act_q;
        pw_act_d  = pw_act_q;
        fw_sh_d   = fw_sh_q;
        pw_sh_d   = pw_sh_q;
        pending_d = pending_q;
        v1_d      = 1'b0;
        wrap1_d   = wrap1_q;

        // A clear wins over ce and drops that sample, but leaves the configuration state alone.
        if (sync_clr) begin
            acc_d = '0;
        end else if (ce) begin
            acc_d   = sum[PHASE_W-1:0];
            wrap1_d = sum[PHASE_W];
            v1_d    = 1'b1;
            if (pending_q) begin
                fw_act_d  = fw_sh_q;
                pw_act_d  = pw_sh_q;
                pending_d = 1'b0;
            end
        end

        // Only possible while nothing is pending, so it never collides with the apply above.
        if (hs) begin
            fw_sh_d   = bus.fw_in;
            pw_sh_d   = bus.pw_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        ph_d    = ph_q;
        wrap2_d = wrap2_q;
        v2_d    = v1_q && !sync_clr;
        if (v1_q) begin
            ph_d    = acc_q + pw_act_q;
            wrap2_d = wrap1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            fw_act_q  <= '0;
            pw_act_q  <= '0;
            fw_sh_q   <= '0;
            pw_sh_q   <= '0;
            pending_q <= 1'b0;
            v1_q      <= 1'b0;
            wrap1_q   <= 1'b0;
            ph_q      <= '0;
            v2_q      <= 1'b0;
            wrap2_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fw_act_q  <= fw_act_d;
            pw_act_q  <= pw_act_d;
            fw_sh_q   <= fw_sh_d;
            pw_sh_q   <= pw_sh_d;
            pending_q <= pending_d;
            v1_q      <= v1_d;
            wrap1_q   <= wrap1_d;
            ph_q      <= ph_d;
            v2_q      <= v2_d;
            wrap2_q   <= wrap2_d;
        end
    end

    assign bus.cfg_ready = !pending_q;

    dds_quad_fold #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W)
    ) u_fold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (sync_clr),
        .valid_i (v2_q),
        .ph_i    (ph_q),
        .wrap_i  (wrap2_q),
        .valid_o (bus.out_valid),
        .addr_o  (bus.rom_addr),
        .neg_o   (bus.neg),
        .wrap_o  (bus.wrap)
    );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: a behavioural accumulator model feeds a scoreboard
// queue that is compared against every out_valid pulse, plus a table of fold vectors.
module tb_dds_phase_gen;
    localparam int PW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic sync_clr = 1'b0;

    dds_phase_gen_if #(.PHASE_W(PW), .ADDR_W(AW)) bus ();

    dds_phase_gen #(.PHASE_W(PW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .sync_clr (sync_clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          neg;
        logic          wrap;
        int            due;
    } sample_t;

    typedef struct {
        logic [PW-1:0] pw;
        logic [AW-1:0] addr;
        logic          neg;
    } vec_t;

    sample_t exp_q[$];
    vec_t    vecs[10];

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    logic [PW-1:0] m_acc, m_fw, m_pw, m_fsh, m_psh;
    logic          m_pending;
    logic [AW-1:0] last_addr;
    logic          last_neg, last_wrap;
    bit            ovr_en = 1'b0;
    logic [AW-1:0] ovr_addr;
    logic          ovr_neg;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [PW-1:0] ph);
        int idx;
        idx = int'(ph[PW-3 -: AW]);
        if (ph[PW-2]) idx = (1 << AW) - 1 - idx;
        return idx[AW-1:0];
    endfunction

    // One clock of stimulus; the model is stepped exactly as the edge will step the DUT.
    task automatic cyc(input bit c, input bit clr, input bit cv,
                       input logic [PW-1:0] fw, input logic [PW-1:0] pw);
        bit            hs;
        logic [PW:0]   sum;
        logic [PW-1:0] ph;
        sample_t       s;
        ce = c;
        sync_clr = clr;
        bus.cfg_valid = cv;
        bus.fw_in = fw;
        bus.pw_in = pw;
        #1;
        check("cfg_ready", {63'd0, bus.cfg_ready}, {63'd0, !m_pending});
        hs = cv && !m_pending;
        if (clr) begin
            m_acc = '0;
            exp_q.delete();
        end else if (c) begin
            if (m_pending) begin
                m_fw = m_fsh;
                m_pw = m_psh;
                m_pending = 1'b0;
            end
            sum = {1'b0, m_acc} + {1'b0, m_fw};
            m_acc = sum[PW-1:0];
            ph = m_acc + m_pw;
            s.addr = ovr_en ? ovr_addr : exp_addr(ph);
            s.neg  = ovr_en ? ovr_neg : ph[PW-1];
            s.wrap = sum[PW];
            s.due  = edge_cnt + 3;
            exp_q.push_back(s);
            ovr_en = 1'b0;
        end
        if (hs) begin
            m_fsh = fw;
            m_psh = pw;
            m_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
        sync_clr = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_cfg_ready", {63'd0, bus.cfg_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_rom_addr", {54'd0, bus.rom_addr}, 64'd0);
        check("rst_neg", {63'd0, bus.neg}, 64'd0);
        check("rst_wrap", {63'd0, bus.wrap}, 64'd0);
        m_acc = '0; m_fw = '0; m_pw = '0; m_fsh = '0; m_psh = '0; m_pending = 1'b0;
        exp_q.delete();
        last_addr = '0; last_neg = 1'b0; last_wrap = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        sample_t s;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got pulse expected none (edge %0d)", edge_cnt);
                end else begin
                    s = exp_q.pop_front();
                    check("latency", 64'(edge_cnt), 64'(s.due));
                    check("rom_addr", {54'd0, bus.rom_addr}, {54'd0, s.addr});
                    check("neg", {63'd0, bus.neg}, {63'd0, s.neg});
                    check("wrap", {63'd0, bus.wrap}, {63'd0, s.wrap});
                    last_addr = s.addr;
                    last_neg = s.neg;
                    last_wrap = s.wrap;
                end
            end else begin
                check("hold_addr", {54'd0, bus.rom_addr}, {54'd0, last_addr});
                check("hold_neg", {63'd0, bus.neg}, {63'd0, last_neg});
                check("hold_wrap", {63'd0, bus.wrap}, {63'd0, last_wrap});
                if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                    s = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_out_valid: got none expected pulse due at edge %0d", s.due);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 10'h000, 1'b0};
        vecs[1] = '{32'h4000_0000, 10'h3FF, 1'b0};
        vecs[2] = '{32'h8000_0000, 10'h000, 1'b1};
        vecs[3] = '{32'hC000_0000, 10'h3FF, 1'b1};
        vecs[4] = '{32'h0010_0000, 10'h001, 1'b0};
        vecs[5] = '{32'h3FF0_0000, 10'h3FF, 1'b0};
        vecs[6] = '{32'h4010_0000, 10'h3FE, 1'b0};
        vecs[7] = '{32'h9230_0000, 10'h123, 1'b1};
        vecs[8] = '{32'hE000_0000, 10'h1FF, 1'b1};
        vecs[9] = '{32'h000F_FFFF, 10'h000, 1'b0};

        bus.cfg_valid = 1'b0;
        bus.fw_in = '0;
        bus.pw_in = '0;
        do_reset();

        // Quarter-turn steps, with idle gaps so the hold behaviour is exercised.
        cyc(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, '0);
            idle(i);
        end
        idle(3);

        // ce held high across quadrant 0 into the mirrored quadrant.
        cyc(1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'h0);
        for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Handshake coinciding with ce: old fw for that sample, new one at the next ce.
        cyc(1'b1, 1'b0, 1'b1, 32'h0200_0000, 32'h1000_0000);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // sync_clr with ce at acc = 0x8000_0000, and clearing samples in flight.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h0800_0000);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Fold vectors with fw = 0, so each sample phase is exactly the offset word.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'h0, vecs[i].pw);
            ovr_en = 1'b1;
            ovr_addr = vecs[i].addr;
            ovr_neg = vecs[i].neg;
            cyc(1'b1, 1'b0, 1'b0, '0, '0);
        end
        idle(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            ovr_en = 1'b1;
            ovr_addr = '0;
            ovr_neg = 1'b1;
            cyc(1'b1, 1'b0, 1'b0, '0, '0);
        end
        idle(3);

        // Reset with two samples in flight; nothing may emerge afterwards.
        cyc(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        do_reset();
        idle(5);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(4);

        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
